// File: rtl/dct_8_stage_sequencer.sv
`default_nettype none
// dct_8_stage_sequencer: drives one vector through NUM_STAGES passes of a shared
// dct_8 stage datapath, holding the intermediate result between passes.
module dct_8_stage_sequencer #(
    parameter int DATA_W     = 512,
    parameter int NUM_STAGES = 4,
    parameter int STG_W      = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic              cfg_bypass,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [DATA_W-1:0] dp_data_out,
    output logic [STG_W-1:0]  dp_stage,
    output logic              dp_valid,
    input  logic              dp_i_ready,
    input  logic [DATA_W-1:0] dp_data_in,
    input  logic              dp_o_valid,
    output logic              dp_o_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  blk_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);

    state_t             state_q;
    logic [DATA_W-1:0]  work_q;
    logic [STG_W-1:0]   stage_q;
    logic [CNT_W-1:0]   blk_q;
    logic               i_ready_q;
    logic               o_valid_q;
    logic               dp_valid_q;
    logic               dp_o_ready_q;
    logic               busy_q;
    logic               pass_done;

    // A pass retires only when the operand is taken and the result is offered together.
    assign pass_done = (state_q == ST_RUN) && dp_i_ready && dp_o_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            work_q       <= '0;
            stage_q      <= '0;
            blk_q        <= '0;
            i_ready_q    <= 1'b1;
            o_valid_q    <= 1'b0;
            dp_valid_q   <= 1'b0;
            dp_o_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        work_q    <= i_data_in;
                        stage_q   <= '0;
                        i_ready_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (cfg_bypass) begin
                            state_q   <= ST_DONE;
                            o_valid_q <= 1'b1;
                        end else begin
                            state_q      <= ST_RUN;
                            dp_valid_q   <= 1'b1;
                            dp_o_ready_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (pass_done) begin
                        work_q <= dp_data_in;
                        if (stage_q == LAST_STG) begin
                            state_q      <= ST_DONE;
                            dp_valid_q   <= 1'b0;
                            dp_o_ready_q <= 1'b0;
                            o_valid_q    <= 1'b1;
                        end else begin
                            stage_q <= stage_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (o_ready) begin
                        blk_q     <= blk_q + 1'b1;
                        state_q   <= ST_IDLE;
                        o_valid_q <= 1'b0;
                        i_ready_q <= 1'b1;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    i_ready_q    <= 1'b1;
                    o_valid_q    <= 1'b0;
                    dp_valid_q   <= 1'b0;
                    dp_o_ready_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign i_ready     = i_ready_q;
    assign o_valid     = o_valid_q;
    assign dp_valid    = dp_valid_q;
    assign dp_o_ready  = dp_o_ready_q;
    assign busy        = busy_q;
    assign blk_cnt     = blk_q;
    // Data buses are zeroed outside their owning state so nothing stale leaks out.
    assign o_data_out  = (state_q == ST_DONE) ? work_q  : '0;
    assign dp_data_out = (state_q == ST_RUN)  ? work_q  : '0;
    assign dp_stage    = (state_q == ST_RUN)  ? stage_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_dct_8_stage_sequencer.sv
`default_nettype none
// tb_dct_8_stage_sequencer: scoreboard bench with an add-(stage+1)-per-lane datapath model.
module tb_dct_8_stage_sequencer;

    localparam int DATA_W = 512;
    localparam int NS     = 4;
    localparam int STG_W  = 3;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] i_data_in = '0;
    logic              i_valid = 1'b0;
    logic              i_ready;
    logic              cfg_bypass = 1'b0;
    logic [DATA_W-1:0] o_data_out;
    logic              o_valid;
    logic              o_ready = 1'b1;
    logic [DATA_W-1:0] dp_data_out;
    logic [STG_W-1:0]  dp_stage;
    logic              dp_valid;
    logic              dp_i_ready = 1'b1;
    logic [DATA_W-1:0] dp_data_in;
    logic              dp_o_valid;
    logic              dp_o_ready;
    logic              busy;
    logic [CNT_W-1:0]  blk_cnt;

    dct_8_stage_sequencer #(
        .DATA_W(DATA_W), .NUM_STAGES(NS), .STG_W(STG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .i_data_in(i_data_in), .i_valid(i_valid), .i_ready(i_ready),
        .cfg_bypass(cfg_bypass),
        .o_data_out(o_data_out), .o_valid(o_valid), .o_ready(o_ready),
        .dp_data_out(dp_data_out), .dp_stage(dp_stage), .dp_valid(dp_valid),
        .dp_i_ready(dp_i_ready), .dp_data_in(dp_data_in), .dp_o_valid(dp_o_valid),
        .dp_o_ready(dp_o_ready), .busy(busy), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    // Combinational datapath: every 64-bit lane gets stage+1 added.
    always_comb begin
        dp_data_in = '0;
        for (int l = 0; l < 8; l++)
            dp_data_in[l*64 +: 64] = dp_data_out[l*64 +: 64] + 64'(dp_stage) + 64'd1;
    end
    assign dp_o_valid = dp_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_blk = 0;
    logic [DATA_W-1:0] sb[$];
    logic [STG_W-1:0]  stg_seq[$];
    bit                saw_dp;

    always @(negedge clk) begin
        if (rst && busy && i_ready) begin
            n_fail++;
            $display("FAIL ready_while_busy: i_ready=%0b busy=%0b required i_ready=0", i_ready, busy);
        end
    end

    function automatic logic [DATA_W-1:0] model(input logic [DATA_W-1:0] v, input bit byp);
        logic [DATA_W-1:0] r;
        r = v;
        if (!byp)
            for (int s = 0; s < NS; s++)
                for (int l = 0; l < 8; l++)
                    r[l*64 +: 64] = r[l*64 +: 64] + 64'(s + 1);
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] fill(input logic [63:0] lane);
        logic [DATA_W-1:0] r;
        for (int l = 0; l < 8; l++) r[l*64 +: 64] = lane;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered #1 after a rising edge; leaves #1 after the accepting edge (cycle 1).
    task automatic accept(input logic [DATA_W-1:0] v, input bit byp);
        int k = 0;
        while (!i_ready && k < 40) begin tick(); k++; end
        n_tests++;
        if (!i_ready) begin
            n_fail++;
            $display("FAIL accept_timeout: i_ready=%0b required 1", i_ready);
        end
        i_data_in  = v;
        cfg_bypass = byp;
        i_valid    = 1'b1;
        sb.push_back(model(v, byp));
        tick();
        i_valid    = 1'b0;
        cfg_bypass = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 1;
        saw_dp = 1'b0;
        stg_seq.delete();
        while (!o_valid && cyc < 100) begin
            if (dp_valid) saw_dp = 1'b1;
            if (dp_valid && dp_i_ready) stg_seq.push_back(dp_stage);
            tick();
            cyc++;
        end
        n_tests++;
        if (!o_valid) begin
            n_fail++;
            $display("FAIL out_timeout: o_valid=%0b after %0d cycles required 1", o_valid, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({o_valid, dp_valid, dp_o_ready, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: ov/dv/dr/busy=%b required 0000", {o_valid, dp_valid, dp_o_ready, busy});
        end
        n_tests++;
        if (blk_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_blk: got %0h required 0", blk_cnt);
        end
        n_tests++;
        if (o_data_out !== '0 || dp_data_out !== '0 || dp_stage !== '0) begin
            n_fail++;
            $display("FAIL reset_data: buses not zero, dp_stage=%0d", dp_stage);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_iready: got %0b required 1", i_ready);
        end
    endtask

    task automatic test_single();
        int cyc;
        logic [DATA_W-1:0] exp;
        accept(fill(64'h10), 1'b0);
        wait_out(cyc);
        n_tests++;
        if (cyc !== NS + 1) begin
            n_fail++;
            $display("FAIL single_latency: got %0d required %0d", cyc, NS + 1);
        end
        exp = sb.pop_front();
        n_tests++;
        if (o_data_out !== exp || exp !== fill(64'h1A)) begin
            n_fail++;
            $display("FAIL single_data: got %h required %h", o_data_out, exp);
        end
        n_tests++;
        if (stg_seq.size() != NS || stg_seq[0] !== 3'd0 || stg_seq[1] !== 3'd1 ||
            stg_seq[2] !== 3'd2 || stg_seq[3] !== 3'd3) begin
            n_fail++;
            $display("FAIL single_stages: got %p required 0,1,2,3", stg_seq);
        end
        tick();
        exp_blk++;
        n_tests++;
        if (blk_cnt !== CNT_W'(exp_blk) || o_valid !== 1'b0 || i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_handshake: blk=%0d ov=%0b ir=%0b required blk=%0d ov=0 ir=1",
                     blk_cnt, o_valid, i_ready, exp_blk);
        end
    endtask

    task automatic test_bypass();
        int cyc;
        logic [DATA_W-1:0] v, exp;
        for (int l = 0; l < 8; l++) v[l*64 +: 64] = 64'(l);
        accept(v, 1'b1);
        wait_out(cyc);
        n_tests++;
        if (cyc !== 1 || saw_dp) begin
            n_fail++;
            $display("FAIL bypass_latency: got %0d dp_seen=%0b required 1 dp_seen=0", cyc, saw_dp);
        end
        exp = sb.pop_front();
        n_tests++;
        if (o_data_out !== exp || exp !== v) begin
            n_fail++;
            $display("FAIL bypass_data: got %h required %h", o_data_out, exp);
        end
        tick();
        exp_blk++;
        n_tests++;
        if (blk_cnt !== CNT_W'(exp_blk)) begin
            n_fail++;
            $display("FAIL bypass_blk: got %0d required %0d", blk_cnt, exp_blk);
        end
    endtask

    task automatic test_stall();
        int cyc = 1;
        int stall = 0;
        logic [DATA_W-1:0] held, exp;
        accept(fill(64'h10), 1'b0);
        while (!o_valid && cyc < 100) begin
            if (dp_valid && dp_stage == 3'd2) begin
                if (stall == 0) held = dp_data_out;
                else begin
                    n_tests++;
                    if (dp_data_out !== held || dp_stage !== 3'd2) begin
                        n_fail++;
                        $display("FAIL stall_stable: stage=%0d data=%h required 2 %h", dp_stage, dp_data_out, held);
                    end
                end
                dp_i_ready = (stall >= 3);
                stall++;
            end else begin
                dp_i_ready = 1'b1;
            end
            tick();
            cyc++;
        end
        dp_i_ready = 1'b1;
        n_tests++;
        if (cyc !== NS + 1 + 3) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d required %0d", cyc, NS + 4);
        end
        exp = sb.pop_front();
        n_tests++;
        if (o_data_out !== exp || exp !== fill(64'h1A)) begin
            n_fail++;
            $display("FAIL stall_data: got %h required %h", o_data_out, exp);
        end
        tick();
        exp_blk++;
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [DATA_W-1:0] exp;
        o_ready = 1'b0;
        accept(fill(64'h1234_5678_0000_0000), 1'b0);
        wait_out(cyc);
        exp = sb.pop_front();
        i_valid   = 1'b1;
        i_data_in = fill(64'hDEAD);
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_data_out !== exp || i_ready !== 1'b0 || blk_cnt !== CNT_W'(exp_blk)) begin
                n_fail++;
                $display("FAIL bp_hold: ov=%0b ir=%0b blk=%0d required 1 0 %0d data_ok=%0b",
                         o_valid, i_ready, blk_cnt, exp_blk, o_data_out === exp);
            end
            tick();
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        n_tests++;
        if (blk_cnt !== CNT_W'(exp_blk) || o_data_out !== exp) begin
            n_fail++;
            $display("FAIL bp_pre: blk=%0d required %0d", blk_cnt, exp_blk);
        end
        tick();
        exp_blk++;
        n_tests++;
        if (blk_cnt !== CNT_W'(exp_blk) || o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_handshake: blk=%0d ov=%0b required %0d 0", blk_cnt, o_valid, exp_blk);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int k = 0;
        logic [DATA_W-1:0] exp;
        accept(fill(64'h55), 1'b0);
        while (!(dp_valid && dp_stage == 3'd1) && k < 20) begin tick(); k++; end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({busy, dp_valid, o_valid, dp_o_ready} !== 4'b0000 || blk_cnt !== '0) begin
            n_fail++;
            $display("FAIL midrst_flags: busy/dv/ov/dr=%b blk=%0d required 0000 0",
                     {busy, dp_valid, o_valid, dp_o_ready}, blk_cnt);
        end
        sb.delete();
        exp_blk = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        accept(fill(64'h77), 1'b0);
        wait_out(cyc);
        exp = sb.pop_front();
        n_tests++;
        if (o_data_out !== exp || cyc !== NS + 1) begin
            n_fail++;
            $display("FAIL midrst_data: lat=%0d got %h required %h", cyc, o_data_out, exp);
        end
        tick();
        exp_blk++;
        n_tests++;
        if (blk_cnt !== CNT_W'(exp_blk)) begin
            n_fail++;
            $display("FAIL midrst_blk: got %0d required %0d", blk_cnt, exp_blk);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [DATA_W-1:0] v, exp;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        exp_blk = 0;
        for (int n = 1; n <= 17; n++) begin
            for (int w = 0; w < 16; w++) v[w*32 +: 32] = $urandom;
            accept(v, n[0]);
            wait_out(cyc);
            exp = sb.pop_front();
            n_tests++;
            if (o_data_out !== exp) begin
                n_fail++;
                $display("FAIL b2b_data_%0d: got %h required %h", n, o_data_out, exp);
            end
            tick();
            exp_blk = (exp_blk + 1) % (1 << CNT_W);
            n_tests++;
            if (blk_cnt !== CNT_W'(exp_blk)) begin
                n_fail++;
                $display("FAIL b2b_blk_%0d: got %0h required %0h", n, blk_cnt, exp_blk);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bypass();
        test_stall();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dct_8_stage_sequencer.md
Name: dct_8_stage_sequencer

Overview:
- Time-multiplexed controller for one shared dct_8 stage datapath: eight 64-bit lanes packed into 512 bits.
- Accepts one 512-bit vector per transaction and drives it through NUM_STAGES passes of the datapath, one pass per stage index.
- Registers the intermediate vector between passes and returns the final vector on a valid/ready output.
- Sits between the visc_DCT FIFO controller and the stage datapath, replacing a hard-wired chain of stage instances.

Parameters:
- DATA_W, 512, packed vector width (8 lanes x 64 bits).
- NUM_STAGES, 4, datapath passes per vector; legal range 1..8.
- STG_W, 3, width of the stage-select field.
- CNT_W, 16, width of the completed-vector counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- i_data_in  in  DATA_W  input vector.
- i_valid  in  1  input valid.
- i_ready  out  1  sequencer can accept an input.
- cfg_bypass  in  1  sampled at input accept; 1 = return the vector unmodified.
- o_data_out  out  DATA_W  result vector.
- o_valid  out  1  result valid.
- o_ready  in  1  downstream ready.
- dp_data_out  out  DATA_W  operand to datapath.
- dp_stage  out  STG_W  stage select to datapath.
- dp_valid  out  1  operand valid.
- dp_i_ready  in  1  datapath accepts operand.
- dp_data_in  in  DATA_W  datapath result.
- dp_o_valid  in  1  datapath result valid.
- dp_o_ready  out  1  sequencer accepts result.
- busy  out  1  state != IDLE.
- blk_cnt  out  CNT_W  completed vectors, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst low, asynchronous), all values forced immediately:
  - state=IDLE, work=0, stage_cnt=0, blk_cnt=0.
  - o_valid=0, dp_valid=0, dp_o_ready=0, busy=0.
  - i_ready=1 from the first cycle after rst deasserts.
- Reset mid-operation discards the in-flight vector. No partial output is ever presented.
- State IDLE:
  - i_ready=1; all other handshake outputs 0.
  - On i_valid: work<=i_data_in, stage_cnt<=0.
  - Next state is DONE if cfg_bypass, else RUN.
- State RUN:
  - dp_valid=1, dp_o_ready=1, dp_data_out=work, dp_stage=stage_cnt.
  - A pass completes in a cycle where dp_i_ready && dp_o_valid. On completion: work<=dp_data_in.
  - If stage_cnt==NUM_STAGES-1, go to DONE; else stage_cnt<=stage_cnt+1 and stay in RUN.
  - Otherwise hold: work, stage_cnt, dp_data_out and dp_stage stay stable.
- State DONE:
  - o_valid=1, o_data_out=work; o_valid and o_data_out hold stable until o_ready.
  - On o_ready: blk_cnt<=blk_cnt+1 (wrapping from 2^CNT_W-1 to 0), go to IDLE.
- i_ready=0 in RUN and DONE. No input is accepted until the cycle after the output handshake, so there is one vector in flight at most.
- o_data_out=0 when not in DONE. dp_data_out=0 and dp_stage=0 when not in RUN.
- Latency with an always-ready, combinational datapath and o_ready=1:
  - Input accepted in cycle 0; o_valid asserts in cycle NUM_STAGES+1; next accept in cycle NUM_STAGES+2.
  - Bypass: o_valid asserts in cycle 1.
- Throughput: one vector per NUM_STAGES+2 cycles.
- Datapath stalls (dp_i_ready or dp_o_valid low) extend RUN cycle-for-cycle; no pass is ever skipped or repeated.
- i_valid asserted while i_ready=0 is ignored; the upstream must hold the data.
- cfg_bypass is relevant only in the accept cycle of IDLE.
- No arithmetic on data; vectors are transferred bit-exact. stage_cnt never exceeds NUM_STAGES-1.

Test Plan:
- Reset then single vector: NUM_STAGES=4, datapath model adds stage+1 to every lane, lanes all 0x10, datapath always ready, o_ready=1 → o_valid in cycle 5 with every lane 0x1A; dp_stage sequence 0,1,2,3; blk_cnt=1.
- Bypass: cfg_bypass=1, lanes 0..7 = 0x0..0x7 → o_valid in cycle 1, o_data_out identical to input, dp_valid never asserted, blk_cnt=1.
- Datapath stall: dp_i_ready held low 3 cycles during stage 2 → dp_stage=2 and dp_data_out stable throughout; output delayed exactly 3 cycles; result value unchanged versus no-stall run.
- Output backpressure: o_ready low 5 cycles in DONE → o_valid and o_data_out stable, i_ready=0, blk_cnt increments only at the handshake cycle.
- Reset mid-RUN: assert rst during stage 1 → busy=0, dp_valid=0, o_valid=0 immediately. Next vector after release completes with the correct value, blk_cnt restarts from 0.
- Counter wrap: CNT_W=4, 17 back-to-back vectors → blk_cnt reads 0xF after the 15th, 0x0 after the 16th, 0x1 after the 17th; i_ready never high while busy.
